// File: rtl/sd_wb_pkg.sv
// Shared constants for the SD emulator Wishbone arbiter: FSM state encoding,
// default watchdog limit and the watchdog counter width rule.
package sd_wb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT0  = 2'd1;
  localparam logic [1:0] GNT1  = 2'd2;
  localparam logic [1:0] ABORT = 2'd3;

  localparam int DEFAULT_TIMEOUT = 255;

  // A disabled watchdog (TIMEOUT=0) still needs a 1-bit counter to stay legal.
  function automatic int wd_cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/sd_wb_watchdog.sv
// Saturating stall counter: expire is high while enabled and the count has
// reached TIMEOUT. TIMEOUT=0 disables it.
module sd_wb_watchdog
  import sd_wb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int            CW    = wd_cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam bit            WD_ON = (TIMEOUT != 0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Kept independent of the slave ack so s_stb_o never depends on s_ack_i.
  assign expire = WD_ON && en && (cnt_q == LIMIT);

endmodule

// File: rtl/sd_wb_arbiter.sv
// Two-master round-robin Wishbone classic arbiter for the SD emulator backing
// store, with burst locking on cyc and a watchdog that aborts hung transfers.
module sd_wb_arbiter
  import sd_wb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,

  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,

  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,

  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,

  output logic            busy_o
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       last_q;
  logic       last_d;

  logic gnt0;
  logic gnt1;
  logic granted;
  logic own_cyc;
  logic own_stb;
  logic wd_en;
  logic wd_clr;
  logic wd_expire;
  logic timeout;

  assign gnt0    = (state_q == GNT0);
  assign gnt1    = (state_q == GNT1);
  assign granted = gnt0 | gnt1;

  // last_q names the owner in GNTn and the aborted master in ABORT.
  assign own_cyc = last_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb = last_q ? m1_stb_i : m0_stb_i;

  assign wd_en   = granted & own_stb;
  assign wd_clr  = ~wd_en | s_ack_i;
  assign timeout = wd_expire & ~s_ack_i;

  sd_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .en     (wd_en),
    .clr    (wd_clr),
    .expire (wd_expire)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (timeout) begin
          state_d = ABORT;
        end else if (!own_cyc) begin
          state_d = IDLE;
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    if (granted) begin
      s_adr_o  = gnt1 ? m1_adr_i : m0_adr_i;
      s_dat_o  = gnt1 ? m1_dat_i : m0_dat_i;
      s_sel_o  = gnt1 ? m1_sel_i : m0_sel_i;
      s_we_o   = gnt1 ? m1_we_i  : m0_we_i;
      s_cyc_o  = own_cyc & ~wd_expire;
      s_stb_o  = own_stb & ~wd_expire;
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
      m0_ack_o = gnt0 & s_ack_i;
      m1_ack_o = gnt1 & s_ack_i;
      m0_err_o = gnt0 & timeout;
      m1_err_o = gnt1 & timeout;
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_sd_wb_arbiter.sv
// Self-checking bench for sd_wb_arbiter: directed arbitration, burst, watchdog
// and reset scenarios, then randomized two-master traffic against a memory model.
module tb_sd_wb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] m_adr  [2];
  logic [DW-1:0] m_dat  [2];
  logic [3:0]    m_sel  [2];
  logic          m_we   [2];
  logic          m_cyc  [2];
  logic          m_stb  [2];
  logic [DW-1:0] m_dato [2];
  logic          m_ack  [2];
  logic          m_err  [2];

  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat;
  logic [3:0]    s_sel;
  logic          s_we, s_cyc, s_stb, busy;

  logic          man_ack;
  logic [DW-1:0] man_dat;
  logic          auto_slave;
  logic          slv_ack;
  logic [DW-1:0] slv_dat;
  logic          s_ack_w;
  logic [DW-1:0] s_dat_w;
  assign s_ack_w = auto_slave ? slv_ack : man_ack;
  assign s_dat_w = auto_slave ? slv_dat : man_dat;

  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] slv_mem [16];
  int n_cmp = 0;
  int n_err = 0;

  sd_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i (clk),       .wb_rst_i (rst),
    .m0_adr_i (m_adr[0]),  .m0_dat_i (m_dat[0]), .m0_sel_i (m_sel[0]),
    .m0_we_i  (m_we[0]),   .m0_cyc_i (m_cyc[0]), .m0_stb_i (m_stb[0]),
    .m0_dat_o (m_dato[0]), .m0_ack_o (m_ack[0]), .m0_err_o (m_err[0]),
    .m1_adr_i (m_adr[1]),  .m1_dat_i (m_dat[1]), .m1_sel_i (m_sel[1]),
    .m1_we_i  (m_we[1]),   .m1_cyc_i (m_cyc[1]), .m1_stb_i (m_stb[1]),
    .m1_dat_o (m_dato[1]), .m1_ack_o (m_ack[1]), .m1_err_o (m_err[1]),
    .s_adr_o  (s_adr),     .s_dat_o  (s_dat),    .s_sel_o  (s_sel),
    .s_we_o   (s_we),      .s_cyc_o  (s_cyc),    .s_stb_o  (s_stb),
    .s_dat_i  (s_dat_w),   .s_ack_i  (s_ack_w),
    .busy_o   (busy)
  );

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i * 17);
  endfunction

  // Behavioural slave: random wait states, one-cycle ack, byte-masked memory.
  initial begin
    int wait_left;
    int idx;
    slv_ack = 1'b0;
    slv_dat = '0;
    wait_left = 0;
    for (int i = 0; i < 16; i++) slv_mem[i] = init_word(i);
    forever begin
      @(posedge clk); #2;
      if (slv_ack) begin
        slv_ack = 1'b0;
      end else if (auto_slave && s_cyc && s_stb) begin
        if (wait_left == 0) begin
          idx = int'(s_adr[5:2]);
          if (s_we) slv_mem[idx] = (slv_mem[idx] & ~byte_mask(s_sel)) | (s_dat & byte_mask(s_sel));
          else      slv_dat = slv_mem[idx];
          slv_ack = 1'b1;
          wait_left = $urandom_range(0, 3);
        end else begin
          wait_left--;
        end
      end
    end
  end

  task automatic go();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_m(input int id, input logic on, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
    m_cyc[id] = on; m_stb[id] = on; m_we[id] = we;
    m_adr[id] = adr; m_dat[id] = dat; m_sel[id] = 4'hF;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) set_m(i, 1'b0, 1'b0, '0, '0);
    man_ack = 1'b0;
  endtask

  task automatic do_reset();
    go(); rst = 1'b1;
    go(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; auto_slave = 1'b0;
    idle_all();
    set_m(0, 1'b1, 1'b0, 32'h4, 32'h0);
    man_dat = 32'hA5A5_A5A5; man_ack = 1'b1;
    sample(); sample();
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (s_cyc !== 1'b0)      begin n_err++; $display("FAIL reset_s_cyc: got %b want 0", s_cyc); end
    n_cmp++; if (s_adr !== '0)        begin n_err++; $display("FAIL reset_s_adr: got %h want 0", s_adr); end
    n_cmp++; if (m_ack[0] !== 1'b0)   begin n_err++; $display("FAIL reset_m0_ack: got %b want 0", m_ack[0]); end
    n_cmp++; if (m_dato[0] !== '0)    begin n_err++; $display("FAIL reset_m0_dat: got %h want 0", m_dato[0]); end
    go(); idle_all(); man_dat = '0; rst = 1'b0;
  endtask

  task automatic test_single();
    go(); set_m(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    sample();
    n_cmp++; if (s_cyc !== 1'b0) begin n_err++; $display("FAIL single_lat0: s_cyc %b want 0", s_cyc); end
    go(); sample();
    n_cmp++; if (s_cyc !== 1'b1) begin n_err++; $display("FAIL single_grant: s_cyc %b want 1", s_cyc); end
    n_cmp++; if (s_adr !== 32'h10) begin n_err++; $display("FAIL single_adr: %h want 10", s_adr); end
    n_cmp++; if (s_dat !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_dat: %h want deadbeef", s_dat); end
    n_cmp++; if (s_we !== 1'b1 || s_sel !== 4'hF) begin n_err++; $display("FAIL single_we_sel: we %b sel %h want 1 f", s_we, s_sel); end
    go(); sample();
    n_cmp++; if (m_ack[0] !== 1'b0) begin n_err++; $display("FAIL single_noack: %b want 0", m_ack[0]); end
    go(); man_ack = 1'b1; sample();
    n_cmp++; if (m_ack[0] !== 1'b1) begin n_err++; $display("FAIL single_ack: %b want 1", m_ack[0]); end
    n_cmp++; if (m_ack[1] !== 1'b0) begin n_err++; $display("FAIL single_m1_ack: %b want 0", m_ack[1]); end
    go(); idle_all(); sample();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_release_busy: %b want 1", busy); end
    go(); sample();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: %b want 0", busy); end
  endtask

  task automatic test_tie();
    do_reset();
    set_m(0, 1'b1, 1'b0, 32'h20, '0);
    set_m(1, 1'b1, 1'b0, 32'h30, '0);
    sample();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL tie_idle0: busy %b want 0", busy); end
    go(); man_ack = 1'b1; man_dat = 32'h1111_0000; sample();
    n_cmp++; if (s_adr !== 32'h20) begin n_err++; $display("FAIL tie_first_m0: s_adr %h want 20", s_adr); end
    n_cmp++; if (m_ack[0] !== 1'b1 || m_ack[1] !== 1'b0) begin n_err++; $display("FAIL tie_ack_route: %b%b want 10", m_ack[0], m_ack[1]); end
    n_cmp++; if (m_dato[0] !== 32'h1111_0000 || m_dato[1] !== 32'h1111_0000) begin n_err++; $display("FAIL tie_fanout: %h %h want 11110000", m_dato[0], m_dato[1]); end
    go(); man_ack = 1'b0; set_m(0, 1'b0, 1'b0, '0, '0); sample();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL tie_release: busy %b want 1", busy); end
    go(); sample();
    n_cmp++; if (busy !== 1'b0 || s_cyc !== 1'b0) begin n_err++; $display("FAIL tie_gap: busy %b s_cyc %b want 0 0", busy, s_cyc); end
    go(); man_ack = 1'b1; man_dat = 32'h2222_0000; sample();
    n_cmp++; if (s_adr !== 32'h30 || s_cyc !== 1'b1) begin n_err++; $display("FAIL tie_second_m1: s_adr %h s_cyc %b want 30 1", s_adr, s_cyc); end
    n_cmp++; if (m_ack[1] !== 1'b1 || m_ack[0] !== 1'b0) begin n_err++; $display("FAIL tie_m1_ack: %b%b want 01", m_ack[0], m_ack[1]); end
    go(); man_ack = 1'b0; set_m(1, 1'b0, 1'b0, '0, '0); sample();
    go(); set_m(0, 1'b1, 1'b0, 32'h24, '0); set_m(1, 1'b1, 1'b0, 32'h34, '0); sample();
    go(); sample();
    n_cmp++; if (s_adr !== 32'h24) begin n_err++; $display("FAIL tie_again_m0: s_adr %h want 24", s_adr); end
    go(); man_ack = 1'b1; sample();
    n_cmp++; if (m_ack[0] !== 1'b1 || m_ack[1] !== 1'b0) begin n_err++; $display("FAIL tie_again_ack: %b%b want 10", m_ack[0], m_ack[1]); end
    go(); idle_all(); sample(); go(); sample();
  endtask

  task automatic test_burst();
    logic [31:0] d;
    go(); set_m(0, 1'b1, 1'b0, 32'h40, '0); sample();
    go(); set_m(1, 1'b1, 1'b0, 32'h80, '0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) go();
      m_adr[0] = 32'h40 + 32'(4 * i); man_ack = 1'b1; d = $urandom; man_dat = d;
      sample();
      n_cmp++; if (s_adr !== 32'h40 + 32'(4 * i)) begin n_err++; $display("FAIL burst_adr%0d: %h", i, s_adr); end
      n_cmp++; if (m_ack[0] !== 1'b1 || m_dato[0] !== d) begin n_err++; $display("FAIL burst_m0_%0d: ack %b dat %h want 1 %h", i, m_ack[0], m_dato[0], d); end
      n_cmp++; if (m_ack[1] !== 1'b0) begin n_err++; $display("FAIL burst_m1_locked%0d: ack %b want 0", i, m_ack[1]); end
    end
    go(); man_ack = 1'b0; set_m(0, 1'b0, 1'b0, '0, '0); sample();
    n_cmp++; if (busy !== 1'b1 || m_ack[1] !== 1'b0) begin n_err++; $display("FAIL burst_release: busy %b m1_ack %b want 1 0", busy, m_ack[1]); end
    go(); sample();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL burst_gap: busy %b want 0", busy); end
    go(); man_ack = 1'b1; sample();
    n_cmp++; if (s_adr !== 32'h80 || m_ack[1] !== 1'b1) begin n_err++; $display("FAIL burst_m1_grant: s_adr %h ack %b want 80 1", s_adr, m_ack[1]); end
    go(); idle_all(); sample(); go(); sample();
  endtask

  task automatic test_timeout();
    go(); set_m(1, 1'b1, 1'b0, 32'hC0, '0); sample();
    for (int k = 1; k <= TO + 1; k++) begin
      go(); sample();
      if (k <= TO) begin
        n_cmp++; if (m_err[1] !== 1'b0 || s_cyc !== 1'b1) begin n_err++; $display("FAIL timeout_stall%0d: err %b s_cyc %b want 0 1", k, m_err[1], s_cyc); end
      end else begin
        n_cmp++; if (m_err[1] !== 1'b1 || m_err[0] !== 1'b0) begin n_err++; $display("FAIL timeout_err: m1 %b m0 %b want 1 0", m_err[1], m_err[0]); end
        n_cmp++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin n_err++; $display("FAIL timeout_force_low: cyc %b stb %b want 0 0", s_cyc, s_stb); end
      end
    end
    go(); sample();
    n_cmp++; if (m_err[1] !== 1'b0 || busy !== 1'b1 || s_cyc !== 1'b0) begin n_err++; $display("FAIL timeout_abort: err %b busy %b cyc %b want 0 1 0", m_err[1], busy, s_cyc); end
    go(); man_ack = 1'b1; sample();
    n_cmp++; if (m_ack[1] !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL timeout_late_ack: ack %b busy %b want 0 1", m_ack[1], busy); end
    go(); idle_all(); sample();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL timeout_hold_abort: busy %b want 1", busy); end
    go(); sample();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL timeout_exit: busy %b want 0", busy); end
  endtask

  task automatic test_collision();
    go(); set_m(0, 1'b1, 1'b1, 32'h50, 32'h55); sample();
    for (int k = 1; k <= TO + 1; k++) begin
      go(); if (k == TO + 1) man_ack = 1'b1; sample();
      if (k <= TO) begin
        n_cmp++; if (m_err[0] !== 1'b0) begin n_err++; $display("FAIL collide_stall%0d: err %b want 0", k, m_err[0]); end
      end else begin
        n_cmp++; if (m_ack[0] !== 1'b1 || m_err[0] !== 1'b0) begin n_err++; $display("FAIL collide_ack_wins: ack %b err %b want 1 0", m_ack[0], m_err[0]); end
      end
    end
    go(); man_ack = 1'b0; sample();
    n_cmp++; if (s_cyc !== 1'b1 || m_err[0] !== 1'b0) begin n_err++; $display("FAIL collide_cleared: cyc %b err %b want 1 0", s_cyc, m_err[0]); end
    for (int k = 2; k <= TO + 1; k++) begin
      go(); sample();
      if (k <= TO) begin
        n_cmp++; if (m_err[0] !== 1'b0) begin n_err++; $display("FAIL collide_restall%0d: err %b want 0", k, m_err[0]); end
      end else begin
        n_cmp++; if (m_err[0] !== 1'b1 || m_err[1] !== 1'b0) begin n_err++; $display("FAIL collide_m0_err: m0 %b m1 %b want 1 0", m_err[0], m_err[1]); end
      end
    end
    go(); idle_all(); sample();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL collide_abort: busy %b want 1", busy); end
    go(); sample();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL collide_exit: busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    go(); set_m(0, 1'b1, 1'b0, 32'h60, '0); sample();
    go(); man_ack = 1'b1; man_dat = 32'h77; sample();
    n_cmp++; if (m_ack[0] !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: ack %b busy %b want 1 1", m_ack[0], busy); end
    @(posedge clk); #3; rst = 1'b1; #1;
    n_cmp++; if (busy !== 1'b0 || s_cyc !== 1'b0) begin n_err++; $display("FAIL rstmid_async: busy %b cyc %b want 0 0", busy, s_cyc); end
    n_cmp++; if (m_ack[0] !== 1'b0 || m_dato[0] !== '0 || s_adr !== '0) begin n_err++; $display("FAIL rstmid_outputs: ack %b dat %h adr %h want 0", m_ack[0], m_dato[0], s_adr); end
    go(); idle_all();
    go(); rst = 1'b0; set_m(0, 1'b1, 1'b0, 32'h64, '0); sample();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: busy %b want 0", busy); end
    go(); sample();
    n_cmp++; if (s_cyc !== 1'b1 || s_adr !== 32'h64) begin n_err++; $display("FAIL rstmid_regrant: cyc %b adr %h want 1 64", s_cyc, s_adr); end
    go(); idle_all(); sample(); go(); sample();
  endtask

  task automatic master_run(input int id, input int nb);
    int len;
    int waited;
    int idx;
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      len = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) begin
        go();
        idx = $urandom_range(0, 15);
        m_cyc[id] = 1'b1; m_stb[id] = 1'b1;
        m_we[id]  = 1'($urandom_range(0, 1));
        m_adr[id] = 32'(idx) << 2;
        m_dat[id] = $urandom;
        m_sel[id] = 4'($urandom_range(1, 15));
        waited = 0;
        sample();
        while (!m_ack[id] && waited < 100) begin waited++; sample(); end
        n_cmp++;
        if (m_ack[id] !== 1'b1) begin
          n_err++; $display("FAIL rnd_m%0d_no_ack: ack %b after %0d cycles want 1", id, m_ack[id], waited);
        end else begin
          n_cmp++; if (m_ack[1-id] !== 1'b0) begin n_err++; $display("FAIL rnd_m%0d_excl: other ack %b want 0", id, m_ack[1-id]); end
          n_cmp++; if (s_adr !== m_adr[id]) begin n_err++; $display("FAIL rnd_m%0d_adr: %h want %h", id, s_adr, m_adr[id]); end
          if (m_we[id]) begin
            ref_mem[idx] = (ref_mem[idx] & ~byte_mask(m_sel[id])) | (m_dat[id] & byte_mask(m_sel[id]));
          end else begin
            n_cmp++; if (m_dato[id] !== ref_mem[idx]) begin n_err++; $display("FAIL rnd_m%0d_rdata[%0d]: %h want %h", id, idx, m_dato[id], ref_mem[idx]); end
          end
        end
      end
      go(); m_cyc[id] = 1'b0; m_stb[id] = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    go(); auto_slave = 1'b1;
    fork
      master_run(0, 20);
      master_run(1, 20);
    join
    go(); go(); sample();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rnd_final_idle: busy %b want 0", busy); end
    auto_slave = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_bound: simulation did not finish in time");
    $fatal(1, "bench aborted");
  end

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_burst();
    test_timeout();
    test_collision();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
